// File: rtl/multicycle_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : multicycle_alu                                                |
// | Purpose  : Execute-stage ALU with valid/ready handshakes and iterative   |
// |            shifts. Define ALU_FAST_SHIFT_EN for up to 4 bits per cycle.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module multicycle_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OP_WIDTH-1:0]   Operation,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] ALUResult,
    output logic                  Zero
);
    localparam int CW = $clog2(DATA_WIDTH);

    localparam logic [OP_WIDTH-1:0] c_OP_AND = 4'b0000;
    localparam logic [OP_WIDTH-1:0] c_OP_OR  = 4'b0001;
    localparam logic [OP_WIDTH-1:0] c_OP_ADD = 4'b0010;
    localparam logic [OP_WIDTH-1:0] c_OP_SUB = 4'b0011;
    localparam logic [OP_WIDTH-1:0] c_OP_XOR = 4'b0100;
    localparam logic [OP_WIDTH-1:0] c_OP_SLT = 4'b0101;
    localparam logic [OP_WIDTH-1:0] c_OP_LUI = 4'b0110;
    localparam logic [OP_WIDTH-1:0] c_OP_SRL = 4'b0111;
    localparam logic [OP_WIDTH-1:0] c_OP_EQ  = 4'b1000;
    localparam logic [OP_WIDTH-1:0] c_OP_SLL = 4'b1001;
    localparam logic [OP_WIDTH-1:0] c_OP_SRA = 4'b1010;
    localparam logic [OP_WIDTH-1:0] c_OP_LT  = 4'b1100;
    localparam logic [OP_WIDTH-1:0] c_OP_GE  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [OP_WIDTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0] r_work;
    logic [CW-1:0]         r_count;

    logic [DATA_WIDTH-1:0] w_result;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [CW-1:0]         w_shamt;
    logic [CW-1:0]         w_step;
    logic                  w_is_shift;
    logic                  w_lt;

    assign w_shamt    = SrcB[CW-1:0];
    assign w_is_shift = (Operation == c_OP_SRL) || (Operation == c_OP_SLL) ||
                        (Operation == c_OP_SRA);
    assign w_lt       = $signed(SrcA) < $signed(SrcB);

    // Single-cycle datapath; shift ops only land here when shamt is zero.
    always_comb begin
        w_result = '0;
        case (Operation)
            c_OP_AND: w_result = SrcA & SrcB;
            c_OP_OR:  w_result = SrcA | SrcB;
            c_OP_ADD: w_result = SrcA + SrcB;
            c_OP_SUB: w_result = SrcA - SrcB;
            c_OP_XOR: w_result = SrcA ^ SrcB;
            c_OP_SLT,
            c_OP_LT:  w_result = {{(DATA_WIDTH-1){1'b0}}, w_lt};
            c_OP_GE:  w_result = {{(DATA_WIDTH-1){1'b0}}, ~w_lt};
            c_OP_EQ:  w_result = {{(DATA_WIDTH-1){1'b0}}, SrcA == SrcB};
            c_OP_LUI: w_result = SrcB;
            c_OP_SRL,
            c_OP_SLL,
            c_OP_SRA: w_result = SrcA;
            default:  w_result = '0;
        endcase
    end

`ifdef ALU_FAST_SHIFT_EN
    assign w_step = (r_count > CW'(4)) ? CW'(4) : r_count;
`else
    assign w_step = CW'(1);
`endif

    // The working register keeps the captured sign bit, so SRA fills correctly.
    always_comb begin
        w_shifted = r_work >> w_step;
        case (r_op)
            c_OP_SLL: w_shifted = r_work << w_step;
            c_OP_SRA: w_shifted = $signed(r_work) >>> w_step;
            default:  w_shifted = r_work >> w_step;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_op      <= '0;
            r_work    <= '0;
            r_count   <= '0;
            ALUResult <= '0;
            Zero      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op     <= Operation;
                        in_ready <= 1'b0;
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_work  <= SrcA;
                            r_count <= w_shamt;
                            r_state <= S_SHIFT;
                        end else begin
                            ALUResult <= w_result;
                            Zero      <= (w_result == '0);
                            out_valid <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work  <= w_shifted;
                    r_count <= r_count - w_step;
                    if (r_count == w_step) begin
                        ALUResult <= w_shifted;
                        Zero      <= (w_shifted == '0);
                        out_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
